// File: rtl/mosaic_gen.sv
// Bayer mosaic generator: reads three colour planes in raster order and emits one
// G/R/B sample per pixel through a 2-entry skid FIFO with ready/valid flow control.
module mosaic_gen #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        rd_r,
  output logic        rd_g,
  output logic        rd_b,
  output logic [13:0] addr_r,
  output logic [13:0] addr_g,
  output logic [13:0] addr_b,
  input  logic [7:0]  rdata_r,
  input  logic [7:0]  rdata_g,
  input  logic [7:0]  rdata_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  pixel_out,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start, no reads, address bus at 0
  // RUN   | issuing reads in raster order as FIFO credit allows
  // FLUSH | all reads issued, draining returned samples to the sink
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [13:0] COL_LAST = 14'(WIDTH - 1);
  localparam logic [13:0] ROW_LAST = 14'(HEIGHT - 1);

  logic [1:0]  state, state_nxt;
  logic [13:0] row, col, pos, addr_q;
  logic [7:0]  fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count, occ_after;
  logic        push, pop, issue, last_pos, frame_end;
  logic [7:0]  push_data;

  // The registered one-hot strobe doubles as the channel select for the byte
  // that comes back at the edge ending the strobe cycle.
  always_comb begin
    push      = rd_r | rd_g | rd_b;
    push_data = rd_r ? rdata_r : (rd_g ? rdata_g : rdata_b);
    pop       = out_valid & out_ready;
    occ_after = count + 2'(push) - 2'(pop);
    last_pos  = (row == ROW_LAST) && (col == COL_LAST);
    issue     = ((state == RUN) || ((state == IDLE) && start)) && (occ_after < 2'd2);
    frame_end = (state == FLUSH) && pop && (count == 2'd1) && !push;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = last_pos ? FLUSH : RUN;
      RUN:     if (issue && last_pos) state_nxt = FLUSH;
      FLUSH:   if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      pos    <= '0;
      addr_q <= '0;
      rd_r   <= 1'b0;
      rd_g   <= 1'b0;
      rd_b   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= frame_end;
      rd_g  <= issue && (row[0] == col[0]);
      rd_r  <= issue && !row[0] && col[0];
      rd_b  <= issue && row[0] && !col[0];
      if (issue) begin
        addr_q <= pos;
        if (last_pos) begin
          row <= '0;
          col <= '0;
          pos <= '0;
        end else begin
          pos <= pos + 14'd1;
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 14'd1;
          end else begin
            col <= col + 14'd1;
          end
        end
      end else if (state_nxt == IDLE) begin
        addr_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= occ_after;
    end
  end

  assign out_valid = (count != 2'd0);
  assign pixel_out = out_valid ? fifo_mem[rd_ptr] : 8'd0;
  assign busy      = (state != IDLE);
  assign addr_r    = addr_q;
  assign addr_g    = addr_q;
  assign addr_b    = addr_q;

endmodule

// File: tb/tb_mosaic_gen.sv
// Scoreboard bench for mosaic_gen: expected samples are queued from a colour-rule
// model at frame start and popped by a monitor on every accepted sample.
module tb_mosaic_gen;
  localparam int W = 128;
  localparam int H = 128;
  localparam int N = W * H;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic        rd_r, rd_g, rd_b, out_valid, busy, done;
  logic        out_ready = 1'b1;
  logic [13:0] addr_r, addr_g, addr_b;
  logic [7:0]  rdata_r, rdata_g, rdata_b, pixel_out;

  logic        s_start = 1'b0;
  logic        s_rd_r, s_rd_g, s_rd_b, s_valid, s_busy, s_done;
  logic        s_ready = 1'b1;
  logic [13:0] s_addr_r, s_addr_g, s_addr_b;
  logic [7:0]  s_rdata_r = 8'h11, s_rdata_g = 8'h22, s_rdata_b = 8'h33, s_pixel;

  always #5 clk = ~clk;

  mosaic_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_r(rd_r), .rd_g(rd_g), .rd_b(rd_b),
    .addr_r(addr_r), .addr_g(addr_g), .addr_b(addr_b),
    .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b),
    .out_valid(out_valid), .out_ready(out_ready), .pixel_out(pixel_out),
    .busy(busy), .done(done)
  );

  mosaic_gen #(.WIDTH(2), .HEIGHT(2)) dut2 (
    .clk(clk), .reset(reset), .start(s_start),
    .rd_r(s_rd_r), .rd_g(s_rd_g), .rd_b(s_rd_b),
    .addr_r(s_addr_r), .addr_g(s_addr_g), .addr_b(s_addr_b),
    .rdata_r(s_rdata_r), .rdata_g(s_rdata_g), .rdata_b(s_rdata_b),
    .out_valid(s_valid), .out_ready(s_ready), .pixel_out(s_pixel),
    .busy(s_busy), .done(s_done)
  );

  int errors = 0, checks = 0;
  int dmode = 0, rmode = 0;
  int rd_exp, issued, accepted, done_cnt, gap_cnt, stall_left, nstb, ch;
  bit mon_en = 0, stall_prev, prev_final, stall_done;
  logic [7:0] held;
  logic [7:0] exp_q[$];

  // 0 = G, 1 = R, 2 = B
  function automatic int colour(int a, int w);
    int row = a / w;
    int col = a % w;
    if (row % 2 == 0) return (col % 2 == 0) ? 0 : 1;
    return (col % 2 == 0) ? 2 : 0;
  endfunction

  function automatic logic [7:0] sample(int dm, int a, int w);
    int c = colour(a, w);
    if (dm == 0) return 8'(a);
    return (c == 0) ? 8'h22 : (c == 1) ? 8'h11 : 8'h33;
  endfunction

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Colour memories: plane contents differ per channel in mode 1
  always_comb begin
    rdata_r = (dmode == 0) ? addr_r[7:0] : 8'h11;
    rdata_g = (dmode == 0) ? addr_g[7:0] : 8'h22;
    rdata_b = (dmode == 0) ? addr_b[7:0] : 8'h33;
  end

  always @(posedge clk) begin
    #1;
    if (rmode == 0) out_ready = 1'b1;
    else if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (!stall_done && accepted >= 3000) begin
      stall_done = 1;
      stall_left = 9;
      out_ready  = 1'b0;
    end else out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (reset && mon_en) begin
      nstb = int'(rd_r) + int'(rd_g) + int'(rd_b);
      if (nstb != 0) begin
        check("strobe_onehot", nstb, 1);
        check("addr_equal", int'(addr_r == addr_g && addr_g == addr_b), 1);
        check("rd_addr", int'(addr_g), rd_exp);
        ch = rd_g ? 0 : (rd_r ? 1 : 2);
        check("rd_channel", ch, colour(rd_exp, W));
        issued++;
        rd_exp++;
        check("outstanding_le2", int'(issued - accepted <= 2), 1);
      end
      if (stall_prev) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_hold", int'(pixel_out), int'(held));
      end
      stall_prev = out_valid && !out_ready;
      held = pixel_out;
      if (rmode == 0 && accepted > 0 && accepted < N && !out_valid) gap_cnt++;
      if (done) begin
        done_cnt++;
        check("done_timing", int'(prev_final), 1);
      end
      prev_final = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_sample", 1, 0);
        else check("pixel", int'(pixel_out), int'(exp_q.pop_front()));
        accepted++;
        prev_final = (accepted == N);
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    rd_exp = 0; issued = 0; accepted = 0; done_cnt = 0; gap_cnt = 0;
    stall_prev = 0; prev_final = 0; stall_done = 0; stall_left = 0;
  endtask

  task automatic start_frame(input int dm);
    clear_model();
    dmode = dm;
    for (int a = 0; a < N; a++) exp_q.push_back(sample(dm, a, W));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("lat_busy", int'(busy), 1);
    check("lat_rd_g", int'(rd_g), 1);
    check("lat_addr0", int'(addr_g), 0);
    @(posedge clk); #1 check("lat_valid", int'(out_valid), 1);
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (done_cnt == 0 && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check({nm, "_done_seen"}, int'(done_cnt > 0), 1);
    repeat (5) @(posedge clk);
    #1;
    check({nm, "_samples"}, accepted, N);
    check({nm, "_done_count"}, done_cnt, 1);
    check({nm, "_queue_empty"}, exp_q.size(), 0);
    check({nm, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_accepted(input int n);
    int t = 0;
    while (accepted < n && t < 40000) begin
      @(posedge clk);
      t++;
    end
    check("reach_sample", int'(accepted >= n), 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_rd"}, int'({rd_r, rd_g, rd_b}), 0);
    check({nm, "_addr"}, int'(addr_r | addr_g | addr_b), 0);
    check({nm, "_valid"}, int'(out_valid), 0);
    check({nm, "_pixel"}, int'(pixel_out), 0);
    check({nm, "_busy_done"}, int'({busy, done}), 0);
  endtask

  initial begin
    int ns, np, nd;
    int sa[8], sc[8], sp[8];

    #12 check_reset_outputs("por");
    @(posedge clk); #1 reset = 1'b1;
    mon_en = 1;

    rmode = 0;
    start_frame(0);
    wait_done("ramp");
    check("ramp_gaps", gap_cnt, 0);

    rmode = 1;
    start_frame(1);
    wait_accepted(500);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("restart_busy", int'(busy), 1);
    wait_done("bayer_stall");

    rmode = 0;
    start_frame(0);
    wait_accepted(1000);
    @(posedge clk); #3 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("post_reset_busy", int'(busy), 0);
    start_frame(0);
    wait_done("after_reset");
    check("idle_addr", int'(addr_g), 0);

    ns = 0; np = 0; nd = 0;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (s_rd_r || s_rd_g || s_rd_b) begin
        if (ns < 8) begin
          sa[ns] = int'(s_addr_g);
          sc[ns] = s_rd_g ? 0 : (s_rd_r ? 1 : 2);
        end
        ns++;
      end
      if (s_valid) begin
        if (np < 8) sp[np] = int'(s_pixel);
        np++;
      end
      if (s_done) nd++;
    end
    check("small_reads", ns, 4);
    check("small_samples", np, 4);
    check("small_done", nd, 1);
    for (int i = 0; i < 4; i++) begin
      check("small_addr", sa[i], i);
      check("small_channel", sc[i], colour(i, 2));
      check("small_pixel", sp[i], int'(sample(1, i, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
